// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera stream emulator: pclk = clk/2, vsync/href framing and RGB444 test patterns.
// Define OV7670_STREAM_GEN_CHECKER_EN to build the 8x8 checkerboard for pattern 3 (otherwise pattern 3 is black).
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    VFP    = 3'd4
  } state_t;

  localparam logic [11:0] LAST_COL  = 12'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0] HREF_COLS = 12'(2 * H_ACTIVE);

  state_t      state, state_nx;
  logic [11:0] col, col_nx;
  logic [11:0] line, line_nx;
  logic [1:0]  pat_q, pat_nx;
  logic [11:0] solid_q, solid_nx;
  logic [11:0] line_last;
  logic        line_end, sect_end, byte_end, frame_last_clk;

  // A byte period closes on the edge where pclk falls, so every counter and
  // every decoded output only moves while pclk is low on the camera side.
  assign byte_end = pclk;
  assign line_end = (col == LAST_COL);
  assign sect_end = line_end && (line == line_last);
  assign frame_last_clk = !pclk && (state == VFP) && sect_end;

  always_comb begin
    line_last = 12'd0;
    case (state)
      VSYNC:   line_last = 12'(VSYNC_LINES - 1);
      VBP:     line_last = 12'(VBP_LINES - 1);
      ACTIVE:  line_last = 12'(V_ACTIVE - 1);
      VFP:     line_last = 12'(VFP_LINES - 1);
      default: line_last = 12'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    col_nx   = col;
    line_nx  = line;
    pat_nx   = pat_q;
    solid_nx = solid_q;
    if (byte_end) begin
      if (state == IDLE) begin
        if (enable) begin
          state_nx = VSYNC;
          pat_nx   = pattern_sel;
          solid_nx = solid_color;
        end
      end else begin
        col_nx = line_end ? 12'd0 : col + 12'd1;
        if (line_end) line_nx = sect_end ? 12'd0 : line + 12'd1;
        if (sect_end) begin
          case (state)
            VSYNC:  state_nx = VBP;
            VBP:    state_nx = ACTIVE;
            ACTIVE: state_nx = VFP;
            VFP: begin
              // Enable is only consulted here, so a dropped enable lets the frame finish.
              if (enable) begin
                state_nx = VSYNC;
                pat_nx   = pattern_sel;
                solid_nx = solid_color;
              end else begin
                state_nx = IDLE;
              end
            end
            default: state_nx = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pclk        <= 1'b0;
      col         <= 12'd0;
      line        <= 12'd0;
      pat_q       <= 2'd0;
      solid_q     <= 12'd0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state      <= state_nx;
      pclk       <= ~pclk;
      col        <= col_nx;
      line       <= line_nx;
      pat_q      <= pat_nx;
      solid_q    <= solid_nx;
      frame_done <= frame_last_clk;
      if (frame_last_clk) frame_count <= frame_count + 8'd1;
    end
  end

  logic [10:0] x;
  logic [2:0]  bar;
  logic [11:0] rgb;

  assign x   = col[11:1];
  assign bar = 3'({x, 3'b000} / 14'(H_ACTIVE));

  always_comb begin
    rgb = 12'h000;
    case (pat_q)
      2'd0: begin
        case (bar)
          3'd0:    rgb = 12'hFFF;
          3'd1:    rgb = 12'hFF0;
          3'd2:    rgb = 12'h0FF;
          3'd3:    rgb = 12'h0F0;
          3'd4:    rgb = 12'hF0F;
          3'd5:    rgb = 12'hF00;
          3'd6:    rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'd1: rgb = {x[3:0], x[3:0], x[3:0]};
      2'd2: rgb = solid_q;
      default: begin
`ifdef OV7670_STREAM_GEN_CHECKER_EN
        rgb = (x[3] ^ line[3]) ? 12'hFFF : 12'h000;
`else
        rgb = 12'h000;
`endif
      end
    endcase
  end

  assign vsync     = (state == VSYNC);
  assign href      = (state == ACTIVE) && (col < HREF_COLS);
  assign d         = !href ? 8'h00 : (col[0] ? rgb[7:0] : {4'h0, rgb[11:8]});
  assign state_dbg = state;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Bench for ov7670_stream_gen: byte-by-byte stream check against a frame-level reference model.
module tb_ov7670_stream_gen;

  localparam int H_ACTIVE    = 8;
  localparam int V_ACTIVE    = 2;
  localparam int H_BLANK     = 2;
  localparam int VSYNC_LINES = 1;
  localparam int VBP_LINES   = 1;
  localparam int VFP_LINES   = 1;
  localparam int LINE_BYTES  = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_CLK   = 2 * LINE_BYTES * (VSYNC_LINES + VBP_LINES + V_ACTIVE + VFP_LINES);
  localparam int HALF        = FRAME_CLK / 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] solid_color = 12'h000;
  logic        pclk, vsync, href, frame_done;
  logic [7:0]  d, frame_count;
  logic [2:0]  state_dbg;

  ov7670_stream_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK),
    .VSYNC_LINES(VSYNC_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
    .solid_color(solid_color), .pclk(pclk), .vsync(vsync), .href(href), .d(d),
    .frame_done(frame_done), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          fd_cnt = 0;
  int          fd_base = 0;
  bit          mon_en = 1'b0;
  logic [10:0] exp_q[$];   // {frame_done, vsync, href, d} per byte period

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clk per step: sample mid-cycle on the falling clk edge, return just after the next rising edge.
  task automatic tick(input int n);
    logic [10:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mon_en) begin
        if (pclk === 1'b1) begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h000;
          chk("stream", {21'd0, frame_done, vsync, href, d}, {21'd0, e});
        end else begin
          chk("fd_low_half", {31'd0, frame_done}, 32'd0);
        end
      end
      if (frame_done === 1'b1) fd_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // reference model
  function automatic logic [11:0] bar_color(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] ref_rgb(input int pat, input logic [11:0] solid, input int x, input int y);
    logic [3:0] v;
    bit checker_on;
`ifdef OV7670_STREAM_GEN_CHECKER_EN
    checker_on = 1'b1;
`else
    checker_on = 1'b0;
`endif
    v = 4'(x % 16);
    case (pat)
      0: return bar_color((x * 8) / H_ACTIVE);
      1: return {v, v, v};
      2: return solid;
      default: return (checker_on && (((x / 8) % 2) != ((y / 8) % 2))) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  task automatic push_frame(input int pat, input logic [11:0] solid);
    logic [11:0] rgb;
    for (int b = 0; b < VSYNC_LINES * LINE_BYTES; b++) exp_q.push_back(11'h200);
    for (int b = 0; b < VBP_LINES * LINE_BYTES; b++) exp_q.push_back(11'h000);
    for (int y = 0; y < V_ACTIVE; y++) begin
      for (int x = 0; x < H_ACTIVE; x++) begin
        rgb = ref_rgb(pat, solid, x, y);
        exp_q.push_back({3'b001, 4'h0, rgb[11:8]});
        exp_q.push_back({3'b001, rgb[7:0]});
      end
      for (int b = 0; b < H_BLANK; b++) exp_q.push_back(11'h000);
    end
    for (int b = 0; b < VFP_LINES * LINE_BYTES - 1; b++) exp_q.push_back(11'h000);
    exp_q.push_back(11'h400);
  endtask

  initial begin
    int          pat;
    logic [11:0] sol;

    // Reset state
    tick(4);
    chk("rst_pclk", {31'd0, pclk}, 32'd0);
    chk("rst_vsync", {31'd0, vsync}, 32'd0);
    chk("rst_href", {31'd0, href}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_count", {24'd0, frame_count}, 32'd0);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);

    // Colour bars from reset, then a mid-frame switch to gradient, a solid frame and random frames
    fd_base = fd_cnt;
    enable = 1'b1;
    pattern_sel = 2'd0;
    exp_q.push_back(11'h000);
    push_frame(0, 12'h000);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick(2 + HALF);
    pattern_sel = 2'd1;
    push_frame(1, 12'h000);
    tick(FRAME_CLK);
    pattern_sel = 2'd2;
    solid_color = 12'hA5C;
    push_frame(2, 12'hA5C);
    tick(FRAME_CLK);
    for (int i = 0; i < 6; i++) begin
      pat = int'($urandom_range(0, 3));
      sol = 12'($urandom);
      pattern_sel = 2'(pat);
      solid_color = sol;
      push_frame(pat, sol);
      tick(FRAME_CLK);
    end

    // Enable dropped in the first active line of the tenth frame
    pat = int'($urandom_range(0, 3));
    sol = 12'($urandom);
    pattern_sel = 2'(pat);
    solid_color = sol;
    push_frame(pat, sol);
    tick(HALF + 2 * 2 * LINE_BYTES + 8);
    enable = 1'b0;
    pattern_sel = 2'(int'($urandom_range(0, 3)));
    tick(FRAME_CLK - (2 * 2 * LINE_BYTES + 8) + 3 * LINE_BYTES);
    chk("drop_fd_pulses", 32'(fd_cnt - fd_base), 32'd10);
    chk("drop_frame_count", {24'd0, frame_count}, 32'd10);
    chk("drop_state_idle", {29'd0, state_dbg}, 32'd0);
    chk("drop_vsync_low", {31'd0, vsync}, 32'd0);
    chk("drop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset pulsed inside ACTIVE of the second frame
    mon_en = 1'b0;
    reset_n = 1'b0;
    tick(3);
    fd_base = fd_cnt;
    pat = int'($urandom_range(0, 2));
    sol = 12'($urandom);
    pattern_sel = 2'(pat);
    solid_color = sol;
    enable = 1'b1;
    exp_q.push_back(11'h000);
    push_frame(pat, sol);
    push_frame(pat, sol);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick(2 + FRAME_CLK + 2 * 2 * LINE_BYTES + 12);
    chk("pre_rst_frame_count", {24'd0, frame_count}, 32'd1);
    chk("pre_rst_href", {31'd0, href}, 32'd1);
    reset_n = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_pclk", {31'd0, pclk}, 32'd0);
    chk("midrst_href", {31'd0, href}, 32'd0);
    chk("midrst_d", {24'd0, d}, 32'd0);
    chk("midrst_vsync", {31'd0, vsync}, 32'd0);
    chk("midrst_frame_count", {24'd0, frame_count}, 32'd0);
    chk("midrst_state", {29'd0, state_dbg}, 32'd0);
    tick(4);
    enable = 1'b0;
    reset_n = 1'b1;
    tick(40);
    chk("midrst_fd_pulses", 32'(fd_cnt - fd_base), 32'd1);
    chk("midrst_frame_count_after", {24'd0, frame_count}, 32'd0);

    // 256 back-to-back frames of pattern 3: frame_count wraps
    reset_n = 1'b0;
    tick(3);
    fd_base = fd_cnt;
    sol = 12'($urandom);
    pattern_sel = 2'd3;
    solid_color = sol;
    enable = 1'b1;
    exp_q.push_back(11'h000);
    for (int f = 0; f < 256; f++) push_frame(3, sol);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick(2 + 255 * FRAME_CLK + HALF);
    chk("wrap_count_255", {24'd0, frame_count}, 32'd255);
    enable = 1'b0;
    tick(HALF + 40);
    chk("wrap_count_0", {24'd0, frame_count}, 32'd0);
    chk("wrap_fd_pulses", 32'(fd_cnt - fd_base), 32'd256);
    chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_state_idle", {29'd0, state_dbg}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
